// File: rtl/arb4_pkg.sv
// ---------------------------------------------------------------------------
// arb4_pkg -- shared types and constants for the 4-way round-robin arbiter.
//   state_t        : arbiter FSM state (IDLE = no grant, BUSY = grant held)
//   N_REQ          : number of requesters
//   IDX_W          : width of a requester index
//   CNT_W          : width of the watchdog counter
//   idx_to_onehot  : requester index -> one-hot grant vector
// ---------------------------------------------------------------------------
package arb4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = {N_REQ{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/arb4_rr_if.sv
// ---------------------------------------------------------------------------
// arb4_rr_if -- request/grant bundle between requesters and the arbiter.
//   i_req   [3:0] : level-sensitive request, bit k = requester k
//   i_done        : pulse, current grant finished
//   o_gnt   [3:0] : one-hot grant, zero when idle
//   o_s     [1:0] : binary index of the granted requester (mux select)
//   o_valid       : a grant is held, qualifies o_s
//   o_tmo         : one-cycle forced-release pulse (ARB4_RR_TIMEOUT_EN only)
// Modports: master = requester/consumer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface arb4_rr_if
  import arb4_pkg::*;
();

  logic [N_REQ-1:0] i_req;
  logic             i_done;
  logic [N_REQ-1:0] o_gnt;
  logic [IDX_W-1:0] o_s;
  logic             o_valid;
`ifdef ARB4_RR_TIMEOUT_EN
  logic             o_tmo;

  modport master (output i_req, output i_done,
                  input  o_gnt, input o_s, input o_valid, input o_tmo);
  modport slave  (input  i_req, input i_done,
                  output o_gnt, output o_s, output o_valid, output o_tmo);
`else
  modport master (output i_req, output i_done,
                  input  o_gnt, input o_s, input o_valid);
  modport slave  (input  i_req, input i_done,
                  output o_gnt, output o_s, output o_valid);
`endif

endinterface

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4 -- combinational rotating-priority picker.
//   req    [3:0] : request vector
//   ptr    [1:0] : highest-priority requester; search order ptr, ptr+1, ...
//   found        : at least one request is set
//   winner [1:0] : first requester found in search order (ptr when none)
// ---------------------------------------------------------------------------
module rr_pick4
  import arb4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] cand;

  // Walk the search order backwards so the lowest offset from ptr wins last.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end else begin
        found  = found;
      end
    end
  end

endmodule

// File: rtl/arb4_rr.sv
// ---------------------------------------------------------------------------
// arb4_rr -- 4-requester round-robin arbiter with grant hold until release.
//   Parameter TMO_CYC (default 16, 2..65535): watchdog limit in BUSY cycles.
//   Optional feature macro: ARB4_RR_TIMEOUT_EN (watchdog + o_tmo).
// Ports:
//   i_clk   : clock, all state on the rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : arb4_rr_if.slave (i_req, i_done in; o_gnt, o_s, o_valid,
//             o_tmo out)
// A grant appears one cycle after arbitration and is held until i_done (or
// the watchdog) releases it. On release the pointer moves past the released
// requester and, if anything is still requesting, the next grant is issued
// on the same edge, so back-to-back grants carry no idle bubble.
// ---------------------------------------------------------------------------
module arb4_rr
  import arb4_pkg::*;
#(
  parameter int TMO_CYC = 16
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  arb4_rr_if.slave bus
);

  state_t           state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [N_REQ-1:0] gnt_r;
  logic [IDX_W-1:0] s_r;
  logic             valid_r;

  logic [IDX_W-1:0] ptr_eff_s;
  logic             found_s;
  logic [IDX_W-1:0] winner_s;
  logic             release_s;

`ifdef ARB4_RR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             tmo_r;
  logic             tmo_hit_s;

  // Watchdog expiry; a simultaneous i_done takes precedence, so no pulse.
  always_comb begin
    tmo_hit_s = (state_r == BUSY) && !bus.i_done && (cnt_r == TMO_LAST);
  end

  // Release source: consumer done or watchdog expiry.
  always_comb begin
    release_s = (state_r == BUSY) && (bus.i_done || tmo_hit_s);
  end
`else
  // Release source: consumer done only.
  always_comb begin
    release_s = (state_r == BUSY) && bus.i_done;
  end
`endif

  // While BUSY the only arbitration that matters is on release, which must
  // already see the pointer advanced past the current owner.
  always_comb begin
    if (state_r == BUSY) begin
      ptr_eff_s = s_r + IDX_W'(1);
    end else begin
      ptr_eff_s = ptr_r;
    end
  end

  rr_pick4 u_pick (
    .req    (bus.i_req),
    .ptr    (ptr_eff_s),
    .found  (found_s),
    .winner (winner_s)
  );

  // Arbiter FSM with registered grant outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      ptr_r   <= {IDX_W{1'b0}};
      gnt_r   <= {N_REQ{1'b0}};
      s_r     <= {IDX_W{1'b0}};
      valid_r <= 1'b0;
`ifdef ARB4_RR_TIMEOUT_EN
      cnt_r   <= {CNT_W{1'b0}};
      tmo_r   <= 1'b0;
`endif
    end else begin
`ifdef ARB4_RR_TIMEOUT_EN
      tmo_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r <= BUSY;
            gnt_r   <= idx_to_onehot(winner_s);
            s_r     <= winner_s;
            valid_r <= 1'b1;
`ifdef ARB4_RR_TIMEOUT_EN
            cnt_r   <= {CNT_W{1'b0}};
`endif
          end else begin
            gnt_r   <= {N_REQ{1'b0}};
            valid_r <= 1'b0;
          end
        end
        BUSY: begin
          if (release_s) begin
            ptr_r <= ptr_eff_s;
`ifdef ARB4_RR_TIMEOUT_EN
            tmo_r <= tmo_hit_s;
            cnt_r <= {CNT_W{1'b0}};
`endif
            if (found_s) begin
              gnt_r   <= idx_to_onehot(winner_s);
              s_r     <= winner_s;
              valid_r <= 1'b1;
            end else begin
              state_r <= IDLE;
              gnt_r   <= {N_REQ{1'b0}};
              valid_r <= 1'b0;
            end
          end else begin
`ifdef ARB4_RR_TIMEOUT_EN
            cnt_r <= cnt_r + CNT_W'(1);
`else
            gnt_r <= gnt_r;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= {N_REQ{1'b0}};
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_gnt   = gnt_r;
  assign bus.o_s     = s_r;
  assign bus.o_valid = valid_r;
`ifdef ARB4_RR_TIMEOUT_EN
  assign bus.o_tmo   = tmo_r;
`endif

endmodule

// File: tb/tb_arb4_rr.sv
// ---------------------------------------------------------------------------
// tb_arb4_rr -- self-checking bench for arb4_rr.
// A behavioural model (integer owner/pointer, modulo-4 search) is advanced on
// every rising edge from the same inputs the DUT sees; all outputs are
// compared against it on the following falling edge. Directed sequences pin
// the model with literal expectations, then random traffic follows.
// ---------------------------------------------------------------------------
module tb_arb4_rr;

  localparam int TB_TMO = 4;

  logic i_clk = 1'b0;
  logic i_rst_n;

  arb4_rr_if bus_if ();

  arb4_rr #(.TMO_CYC(TB_TMO)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus_if.slave)
  );

  always #5 i_clk = ~i_clk;

  int n_err = 0;
  int n_chk = 0;

  // Behavioural model state
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_tmo   = 1'b0;

  function automatic int pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    bit fire;
    if (!i_rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_tmo = 1'b0;
      return;
    end
    fire = 1'b0;
`ifdef ARB4_RR_TIMEOUT_EN
    if (m_busy && !bus_if.i_done && m_cnt == TB_TMO - 1) fire = 1'b1;
`endif
    m_tmo = fire;
    if (m_busy) begin
      if (bus_if.i_done || fire) begin
        m_ptr = (m_owner + 1) % 4;
        w = pick(bus_if.i_req, m_ptr);
        m_cnt = 0;
        if (w >= 0) m_owner = w;
        else m_busy = 1'b0;
      end else begin
        m_cnt++;
      end
    end else begin
      w = pick(bus_if.i_req, m_ptr);
      if (w >= 0) begin
        m_busy = 1'b1; m_owner = w; m_cnt = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare();
    check("model_gnt", 32'(bus_if.o_gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
    check("model_s", 32'(bus_if.o_s), 32'(m_owner));
    check("model_valid", 32'(bus_if.o_valid), 32'(m_busy));
`ifdef ARB4_RR_TIMEOUT_EN
    check("model_tmo", 32'(bus_if.o_tmo), 32'(m_tmo));
`endif
  endtask

  task automatic cyc();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    compare();
  endtask

  localparam logic [3:0] RR_ORDER = 4'b0000;
  int order [4] = '{1, 2, 3, 0};

  initial begin
    i_rst_n       = 1'b0;
    bus_if.i_req  = 4'b0000;
    bus_if.i_done = 1'b0;
    cyc();
    cyc();
    check("rst_gnt", 32'(bus_if.o_gnt), 32'h0);
    check("rst_s", 32'(bus_if.o_s), 32'h0);
    check("rst_valid", 32'(bus_if.o_valid), 32'h0);

    // Single request, one-cycle latency
    i_rst_n = 1'b1; bus_if.i_req = 4'b0100;
    cyc();
    check("first_gnt", 32'(bus_if.o_gnt), 32'h4);
    check("first_s", 32'(bus_if.o_s), 32'h2);
    check("first_valid", 32'(bus_if.o_valid), 32'h1);

    // Release to idle: o_s holds
    bus_if.i_req = 4'b0000; bus_if.i_done = 1'b1;
    cyc();
    check("idle_valid", 32'(bus_if.o_valid), 32'h0);
    check("idle_s", 32'(bus_if.o_s), 32'h2);
    bus_if.i_done = 1'b0;

    // All requesting, done held high: rotation 0,1,2,3,0 without bubbles
    i_rst_n = 1'b0; cyc();
    i_rst_n = 1'b1; bus_if.i_req = 4'b1111;
    cyc();
    check("rr_gnt0", 32'(bus_if.o_gnt), 32'h1);
    bus_if.i_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("rr_gnt", 32'(bus_if.o_gnt), 32'd1 << order[i]);
      check("rr_valid", 32'(bus_if.o_valid), 32'h1);
    end
    bus_if.i_done = 1'b0;

    // Grant on 1 held while its request drops
    i_rst_n = 1'b0; cyc();
    i_rst_n = 1'b1; bus_if.i_req = 4'b0010;
    cyc();
    bus_if.i_req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("hold_gnt", 32'(bus_if.o_gnt), 32'h2);
    end

    // Move to 3, re-grant 3 as sole requester, then release to idle
    bus_if.i_req = 4'b1000; bus_if.i_done = 1'b1;
    cyc();
    check("to3_gnt", 32'(bus_if.o_gnt), 32'h8);
    cyc();
    check("regrant3_gnt", 32'(bus_if.o_gnt), 32'h8);
    check("regrant3_valid", 32'(bus_if.o_valid), 32'h1);
    bus_if.i_req = 4'b0000;
    cyc();
    check("idle3_s", 32'(bus_if.o_s), 32'h3);
    check("idle3_valid", 32'(bus_if.o_valid), 32'h0);
    bus_if.i_done = 1'b0;

    // Reset while busy on 2, then 0 wins first
    bus_if.i_req = 4'b0100;
    cyc();
    check("busy2_gnt", 32'(bus_if.o_gnt), 32'h4);
    i_rst_n = 1'b0;
    cyc();
    check("rstbusy_valid", 32'(bus_if.o_valid), 32'h0);
    i_rst_n = 1'b1; bus_if.i_req = 4'b0101;
    cyc();
    check("post_rst_gnt", 32'(bus_if.o_gnt), 32'h1);

    // Watchdog: forced release after TB_TMO busy cycles
    i_rst_n = 1'b0; bus_if.i_req = 4'b0000; cyc();
    i_rst_n = 1'b1; bus_if.i_req = 4'b0001;
    cyc();
    for (int i = 1; i <= TB_TMO + 1; i++) begin
      cyc();
      check("wd_gnt", 32'(bus_if.o_gnt), 32'h1);
`ifdef ARB4_RR_TIMEOUT_EN
      check("wd_tmo", 32'(bus_if.o_tmo), (i == TB_TMO) ? 32'h1 : 32'h0);
`endif
    end
    // Counter is at 1 here; i_done exactly on the expiry cycle gives no pulse
    for (int i = 0; i < TB_TMO - 2; i++) cyc();
    bus_if.i_done = 1'b1;
    cyc();
    bus_if.i_done = 1'b0;
    cyc();
`ifdef ARB4_RR_TIMEOUT_EN
    check("wd_done_tmo", 32'(bus_if.o_tmo), 32'h0);
`endif
    check("wd_done_gnt", 32'(bus_if.o_gnt), 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      bus_if.i_req  = 4'($urandom_range(0, 15));
      bus_if.i_done = ($urandom_range(0, 3) == 0);
      i_rst_n       = ($urandom_range(0, 60) != 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
